// File: rtl/jx2_dc_mem_bridge.sv
// jx2_dc_mem_bridge: serializes L1 data-cache memory-port requests
// onto a 32-bit single-outstanding external bus.
module jx2_dc_mem_bridge (
    input  logic         clock,
    input  logic         reset,
    input  logic [47:0]  memPcAddr,
    input  logic [4:0]   memPcOpm,
    input  logic [127:0] memPcDataI,
    output logic [127:0] memPcDataO,
    output logic [1:0]   memPcOK,
    output logic         busReq,
    output logic         busWr,
    output logic [31:0]  busAddr,
    output logic [3:0]   busSel,
    output logic [31:0]  busWData,
    input  logic [31:0]  busRData,
    input  logic         busAck,
    input  logic         busErr
);

    localparam logic [1:0] OK_READY = 2'd0;
    localparam logic [1:0] OK_DONE  = 2'd1;
    localparam logic [1:0] OK_HOLD  = 2'd2;
    localparam logic [1:0] OK_FAULT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE,
        FAIL
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]   beat;
    logic [1:0]   beat_nxt;
    logic [1:0]   beat_inc;
    logic [31:0]  addr_q;
    logic [4:0]   opm_q;
    logic [127:0] data_q;
    logic         latch;

    logic         req_nxt;
    logic         wr_nxt;
    logic [31:0]  addr_nxt;
    logic [3:0]   sel_nxt;
    logic [31:0]  wdata_nxt;
    logic [1:0]   ok_nxt;
    logic [127:0] dout_nxt;

    // Upper address bits lie outside the 32-bit bus; OE is implied by !WR.
    logic unused_bits;
    assign unused_bits = ^{memPcAddr[47:32], opm_q[3]};

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] a
    );
        return ((size == 2'd1) && (a == 2'd3)) ||
               ((size == 2'd2) && (a != 2'd0));
    endfunction

    function automatic logic [1:0] last_idx(
        input logic       z0,
        input logic [1:0] size
    );
        logic [1:0] n;
        n = 2'd0;
        if (size == 2'd3) begin
            n = z0 ? 2'd3 : 2'd1;
        end
        return n;
    endfunction

    function automatic logic [31:0] beat_addr(
        input logic [31:0] a,
        input logic [1:0]  k
    );
        return {a[31:2], 2'b00} + {28'd0, k, 2'b00};
    endfunction

    function automatic logic [3:0] lane_sel(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic [3:0] s;
        unique case (size)
            2'd0:    s = 4'b0001 << a;
            2'd1:    s = 4'b0011 << a;
            default: s = 4'hF;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] beat_wdata(
        input logic         multi,
        input logic [1:0]   a,
        input logic [127:0] d,
        input logic [1:0]   k
    );
        logic [31:0] w;
        if (multi) begin
            w = d[{k, 5'b00000} +: 32];
        end else begin
            w = d[31:0] << {a, 3'b000};
        end
        return w;
    endfunction

    // Right-align the addressed lanes, then sign- or zero-extend.
    function automatic logic [63:0] load_ext(
        input logic        z0,
        input logic [1:0]  size,
        input logic [1:0]  a,
        input logic [31:0] r
    );
        logic [31:0] s;
        logic [63:0] v;
        s = r >> {a, 3'b000};
        unique case (size)
            2'd0:    v = z0 ? {56'd0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
            2'd1:    v = z0 ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            default: v = z0 ? {32'd0, s}       : {{32{s[31]}}, s};
        endcase
        return v;
    endfunction

    assign beat_inc = beat + 2'd1;

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        latch     = 1'b0;
        req_nxt   = busReq;
        wr_nxt    = busWr;
        addr_nxt  = busAddr;
        sel_nxt   = busSel;
        wdata_nxt = busWData;
        ok_nxt    = memPcOK;
        dout_nxt  = memPcDataO;
        unique case (state)
            IDLE: begin
                ok_nxt  = OK_READY;
                req_nxt = 1'b0;
                if (memPcOpm != 5'd0) begin
                    latch    = 1'b1;
                    dout_nxt = '0;
                    if ((memPcOpm[4:3] == 2'b11) ||
                        misaligned(memPcOpm[1:0], memPcAddr[1:0])) begin
                        state_nxt = FAIL;
                        ok_nxt    = OK_FAULT;
                    end else begin
                        state_nxt = ISSUE;
                        ok_nxt    = OK_HOLD;
                        req_nxt   = 1'b1;
                        beat_nxt  = 2'd0;
                        wr_nxt    = memPcOpm[4];
                        addr_nxt  = beat_addr(memPcAddr[31:0], 2'd0);
                        sel_nxt   = lane_sel(memPcOpm[1:0],
                                             memPcAddr[1:0]);
                        wdata_nxt = beat_wdata(memPcOpm[1:0] == 2'd3,
                                               memPcAddr[1:0],
                                               memPcDataI, 2'd0);
                    end
                end
            end
            ISSUE: begin
                if (busErr) begin
                    state_nxt = FAIL;
                    ok_nxt    = OK_FAULT;
                    req_nxt   = 1'b0;
                end else if (busAck) begin
                    if (!opm_q[4]) begin
                        if (opm_q[1:0] == 2'd3) begin
                            dout_nxt[{beat, 5'b00000} +: 32] = busRData;
                        end else begin
                            dout_nxt = {64'd0, load_ext(opm_q[2],
                                        opm_q[1:0], addr_q[1:0],
                                        busRData)};
                        end
                    end
                    if (beat == last_idx(opm_q[2], opm_q[1:0])) begin
                        state_nxt = DONE;
                        ok_nxt    = OK_DONE;
                        req_nxt   = 1'b0;
                    end else begin
                        beat_nxt  = beat_inc;
                        addr_nxt  = beat_addr(addr_q, beat_inc);
                        wdata_nxt = beat_wdata(1'b1, addr_q[1:0],
                                               data_q, beat_inc);
                    end
                end
            end
            DONE, FAIL: begin
                req_nxt = 1'b0;
                if (memPcOpm == 5'd0) begin
                    state_nxt = IDLE;
                    ok_nxt    = OK_READY;
                end
            end
            default: begin
                state_nxt = IDLE;
                ok_nxt    = OK_READY;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            beat       <= 2'd0;
            addr_q     <= '0;
            opm_q      <= '0;
            data_q     <= '0;
            busReq     <= 1'b0;
            busWr      <= 1'b0;
            busAddr    <= '0;
            busSel     <= '0;
            busWData   <= '0;
            memPcOK    <= OK_READY;
            memPcDataO <= '0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            busReq     <= req_nxt;
            busWr      <= wr_nxt;
            busAddr    <= addr_nxt;
            busSel     <= sel_nxt;
            busWData   <= wdata_nxt;
            memPcOK    <= ok_nxt;
            memPcDataO <= dout_nxt;
            if (latch) begin
                addr_q <= memPcAddr[31:0];
                opm_q  <= memPcOpm;
                data_q <= memPcDataI;
            end
        end
    end

endmodule

// File: doc/jx2_dc_mem_bridge.md
# jx2_dc_mem_bridge

Downstream memory-side stage of the L1 data cache tile. It accepts the tile's 128-bit memory port requests (line fill, line write-back, uncached MMIO bypass) and serializes them onto a 32-bit single-outstanding external bus. It returns status on the tile's 2-bit OK channel. It sits between the data cache tile and the external bus / SRAM controller.

## Interface
Parameters:
- none (bus width fixed at 32 bits, line size fixed at 128 bits / 4 beats)

Ports:
- clock  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-low; all state and outputs cleared immediately while low
- memPcAddr  in  48  request byte address from cache tile
- memPcOpm  in  5  request opcode {WR, OE, Z0, S1, S0}; 0 = no request
- memPcDataI  in  128  store data from cache tile (line write-back or bypass store)
- memPcDataO  out  128  load data to cache tile
- memPcOK  out  2  status: 0 READY, 1 OK, 2 HOLD, 3 FAULT
- busReq  out  1  bus request; held until busAck or busErr
- busWr  out  1  1 = write beat, 0 = read beat
- busAddr  out  32  beat byte address, bits [1:0] always 0
- busSel  out  4  byte-lane enables
- busWData  out  32  write beat data
- busRData  in  32  read beat data, valid with busAck
- busAck  in  1  beat complete
- busErr  in  1  beat failed; takes priority over busAck in the same cycle

## Operation
- States: IDLE, ISSUE, DONE, FAIL.
- IDLE:
  - Output memPcOK=READY.
  - When memPcOpm!=0, latch addr, opm and data, then go to ISSUE.
  - memPcOpm[4:3]==2'b11 (read+write) is unsupported: go directly to FAIL.
- Op classes:
  - opm[2:0]==3'b111 (line): 4 beats.
  - 3'b011 or 3'b111-less QWord: 2 beats.
  - All other sizes: 1 beat.
  - Beat k address is {addr[31:2],2'b00}+4k, modulo 2^32.
- Line write: beat k drives memPcDataI[32k+31:32k], busSel=4'hF.
- Line read: beat k data goes to memPcDataO[32k+31:32k].
- QWord: same lane mapping for bits [63:0]; memPcDataO[127:64]=0.
- Sub-word ops: one beat.
  - Byte: busSel=1<<addr[1:0].
  - Word: busSel=4'b0011<<addr[1:0].
  - DWord: busSel=4'hF.
  - Word with addr[1:0]==3, or DWord with addr[1:0]!=0 (misaligned): go to FAIL without a bus beat.
  - Store data: memPcDataI[31:0] shifted left by 8*addr[1:0].
  - Load result: selected lanes right-aligned into memPcDataO[63:0]. Sign-extend if Z0=0, zero-extend if Z0=1. memPcDataO[127:64]=0.
- ISSUE:
  - busReq=1, memPcOK=HOLD.
  - On busAck: capture data and advance the beat counter. After the last beat go to DONE; otherwise stay in ISSUE with the next address, so beats run back-to-back.
  - On busErr: drop the remaining beats and go to FAIL.
- DONE/FAIL:
  - busReq=0; memPcOK is OK (DONE) or FAULT (FAIL).
  - memPcDataO holds its value.
  - Stay in the state while memPcOpm!=0. When memPcOpm==0, go to IDLE.
- memPcOpm/addr/data changes after latch are ignored until the bridge returns to IDLE.
- Reset values: state IDLE, memPcOK=0, memPcDataO=0, busReq=0, busWr=0, busAddr=0, busSel=0, busWData=0.
- A reset asserted mid-beat abandons the beat; the bus must tolerate the request being withdrawn.

## Timing
- All outputs are registered.
- Cycle 0: IDLE samples memPcOpm!=0.
- Cycle 1: ISSUE, busReq=1, memPcOK=HOLD.
- Zero-wait bus:
  - A line op acks in cycles 1–4; memPcOK=OK from cycle 5.
  - A single-beat op acks in cycle 1; OK from cycle 2.
- Each wait cycle on busAck adds exactly one cycle.
- Misaligned or read+write request: memPcOK=FAULT from cycle 1, busReq never asserted.
- After memPcOpm falls to 0 in DONE/FAIL, memPcOK=READY on the next cycle.
- A new request is sampled no earlier than that READY cycle (minimum 1 idle cycle between requests).
- busAddr/busWr/busSel/busWData change only on the edge that accepts an ack, or on entry to ISSUE.

## Test plan
- Line fill: opm=5'b01111, addr=0x1000, zero-wait acks returning 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Expect busAddr 0x1000/04/08/0C, busSel=F.
  - Expect memPcOK=OK at cycle 5, memPcDataO=0x44444444_33333333_22222222_11111111.
- Line write-back: opm=5'b10111, data=0xDDDD…_AAAA…, ack delayed 2 cycles per beat.
  - Expect busWr=1 and 4 beats with the correct words in order.
  - Expect HOLD for 12 cycles, then OK.
- Bypass byte load: opm=5'b01000, addr=0x8003, busRData=0x80FFFFFF.
  - Expect busSel=4'b1000 and memPcDataO[63:0]=0xFFFFFFFFFFFFFF80.
  - Repeat with opm=5'b01100: expect 0x80.
- Misaligned DWord: opm=5'b01010, addr=0x2002.
  - Expect FAULT at cycle 1, busReq never 1.
  - Drop opm: expect READY the next cycle.
- Bus error: line fill where beat 2 asserts busErr together with busAck.
  - Expect FAULT, no beat 3.
  - Expect FAULT to persist until opm=0.
- Reset mid-op: assert reset low during beat 1 of a line fill.
  - Expect busReq=0 and memPcOK=0 immediately (asynchronous).
  - After release with opm=0: expect IDLE/READY.
